// File: rtl/morra_partita.sv
// Match controller for two-player morra cinese: judges one round per clock,
// keeps round count and scores, applies the no-repeat rule and decides the match.
module morra_partita #(
   parameter int MIN_MANCHE = 4,
   parameter int CNT_W      = 5,
   parameter int LEAD       = 2,
   parameter int NO_REPEAT  = 1
) (
   input  logic             clk,
   input  logic             inizio,
   input  logic [1:0]       primo,
   input  logic [1:0]       secondo,
   output logic [1:0]       manche,
   output logic [1:0]       partita,
   output logic [CNT_W-1:0] conteggio
);

   typedef enum logic {GIOCO = 1'b0, FINE = 1'b1} state_t;

   localparam logic [1:0]       RES_NONE = 2'b00;
   localparam logic [1:0]       RES_P2   = 2'b01;
   localparam logic [1:0]       RES_P1   = 2'b10;
   localparam logic [1:0]       RES_DRAW = 2'b11;
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_MANCHE);
   localparam logic [CNT_W-1:0] LEAD_C   = CNT_W'(LEAD);
   localparam logic             NR_EN    = (NO_REPEAT != 0);

   // a beats b: carta over sasso, sasso over forbice, forbice over carta
   function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
      return ((a == 2'b10) && (b == 2'b01)) ||
             ((a == 2'b01) && (b == 2'b11)) ||
             ((a == 2'b11) && (b == 2'b10));
   endfunction

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_max;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_s1;
   logic [CNT_W-1:0] r_s2;
   logic             r_mem_vld;
   logic             r_mem_p1;
   logic [1:0]       r_mem_move;
   logic [1:0]       r_manche;
   logic [1:0]       r_partita;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_s1_nxt;
   logic [CNT_W-1:0] w_s2_nxt;
   logic             w_mem_vld_nxt;
   logic             w_mem_p1_nxt;
   logic [1:0]       w_mem_move_nxt;
   logic [1:0]       w_manche_nxt;
   logic [1:0]       w_partita_nxt;
   logic             w_repeat;
   logic [1:0]       w_res;
   logic             w_end;

   // Round judgement on the raw moves, including the no-repeat veto
   always_comb begin
      w_repeat = NR_EN && r_mem_vld &&
                 (r_mem_p1 ? (primo == r_mem_move) : (secondo == r_mem_move));
      if ((primo == 2'b00) || (secondo == 2'b00) || w_repeat) begin
         w_res = RES_NONE;
      end else if (primo == secondo) begin
         w_res = RES_DRAW;
      end else if (beats(primo, secondo)) begin
         w_res = RES_P1;
      end else begin
         w_res = RES_P2;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_s1_nxt       = r_s1;
      w_s2_nxt       = r_s2;
      w_mem_vld_nxt  = r_mem_vld;
      w_mem_p1_nxt   = r_mem_p1;
      w_mem_move_nxt = r_mem_move;
      w_manche_nxt   = RES_NONE;
      w_partita_nxt  = r_partita;
      w_end          = 1'b0;

      if ((r_state == GIOCO) && (w_res != RES_NONE)) begin
         w_cnt_nxt    = r_cnt + CNT_W'(1);
         w_manche_nxt = w_res;
         if (w_res == RES_DRAW) begin
            w_mem_vld_nxt = 1'b0;
         end else begin
            if (w_res == RES_P1) begin
               w_s1_nxt = r_s1 + CNT_W'(1);
            end else begin
               w_s2_nxt = r_s2 + CNT_W'(1);
            end
            w_mem_vld_nxt  = 1'b1;
            w_mem_p1_nxt   = (w_res == RES_P1);
            w_mem_move_nxt = (w_res == RES_P1) ? primo : secondo;
         end

         // End check sees this round's updated count and scores
         w_end = (w_cnt_nxt == r_max) ||
                 ((w_cnt_nxt >= MIN_C) && (abs_diff(w_s1_nxt, w_s2_nxt) >= LEAD_C));
         if (w_end) begin
            w_state_nxt = FINE;
            if (w_s1_nxt > w_s2_nxt) begin
               w_partita_nxt = RES_P1;
            end else if (w_s2_nxt > w_s1_nxt) begin
               w_partita_nxt = RES_P2;
            end else begin
               w_partita_nxt = RES_DRAW;
            end
         end
      end
   end

   // inizio both resets and latches the round budget from the moves
   always_ff @(posedge clk) begin
      if (inizio) begin
         r_state    <= GIOCO;
         r_max      <= MIN_C + CNT_W'({primo, secondo});
         r_cnt      <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
         r_mem_vld  <= 1'b0;
         r_mem_p1   <= 1'b0;
         r_mem_move <= 2'b00;
         r_manche   <= RES_NONE;
         r_partita  <= RES_NONE;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_s1       <= w_s1_nxt;
         r_s2       <= w_s2_nxt;
         r_mem_vld  <= w_mem_vld_nxt;
         r_mem_p1   <= w_mem_p1_nxt;
         r_mem_move <= w_mem_move_nxt;
         r_manche   <= w_manche_nxt;
         r_partita  <= w_partita_nxt;
      end
   end

   assign manche    = r_manche;
   assign partita   = r_partita;
   assign conteggio = r_cnt;

endmodule

// File: tb/tb_morra_partita.sv
// Bench for morra_partita: two DUTs (no-repeat on/off) checked every cycle
// against a score-keeping model, plus hand-computed spot checks.
module tb_morra_partita;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          inizio = 1'b0;
   logic [1:0]    primo = 2'b00;
   logic [1:0]    secondo = 2'b00;
   logic [1:0]    manche_a, partita_a, manche_b, partita_b;
   logic [CW-1:0] cnt_a, cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   morra_partita #(.MIN_MANCHE(4), .CNT_W(CW), .LEAD(2), .NO_REPEAT(1)) dut_a (
      .clk(clk), .inizio(inizio), .primo(primo), .secondo(secondo),
      .manche(manche_a), .partita(partita_a), .conteggio(cnt_a));

   morra_partita #(.MIN_MANCHE(4), .CNT_W(CW), .LEAD(2), .NO_REPEAT(0)) dut_b (
      .clk(clk), .inizio(inizio), .primo(primo), .secondo(secondo),
      .manche(manche_b), .partita(partita_b), .conteggio(cnt_b));

   // Model state per DUT: index 0 = no-repeat on, 1 = off
   int  m_max[2], m_cnt[2], m_s1[2], m_s2[2], m_who[2], m_mv[2];
   int  e_manche[2], e_partita[2];
   bit  m_over[2];
   bit  m_valid = 1'b0;

   function automatic int beaten_by(input int m);
      case (m)
         2: return 1;
         1: return 3;
         3: return 2;
         default: return 0;
      endcase
   endfunction

   // 0 invalid, 1 player 2, 2 player 1, 3 draw
   function automatic int judge(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      if (a == b) return 3;
      return (beaten_by(a) == b) ? 2 : 1;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int a, b, r, d;
         a = int'(primo);
         b = int'(secondo);
         if (inizio) begin
            m_max[k] = 4 + a * 4 + b;
            m_cnt[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
            m_who[k] = 0; m_mv[k] = 0; m_over[k] = 0;
            e_manche[k] = 0; e_partita[k] = 0;
         end else if (m_over[k]) begin
            e_manche[k] = 0;
         end else begin
            r = judge(a, b);
            if (k == 0 && r != 0 && m_who[k] != 0) begin
               if ((m_who[k] == 2 && a == m_mv[k]) || (m_who[k] == 1 && b == m_mv[k])) r = 0;
            end
            e_manche[k] = r;
            if (r != 0) begin
               m_cnt[k]++;
               if (r == 3) begin
                  m_who[k] = 0;
               end else begin
                  if (r == 2) m_s1[k]++; else m_s2[k]++;
                  m_who[k] = r;
                  m_mv[k]  = (r == 2) ? a : b;
               end
               d = m_s1[k] - m_s2[k];
               if (d < 0) d = -d;
               if (m_cnt[k] == m_max[k] || (m_cnt[k] >= 4 && d >= 2)) begin
                  m_over[k] = 1;
                  e_partita[k] = (m_s1[k] > m_s2[k]) ? 2 : (m_s2[k] > m_s1[k]) ? 1 : 3;
               end
            end
         end
      end
      if (inizio) m_valid = 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("a_manche",  int'(manche_a),  e_manche[0]);
         chk("a_partita", int'(partita_a), e_partita[0]);
         chk("a_cnt",     int'(cnt_a),     m_cnt[0]);
         chk("b_manche",  int'(manche_b),  e_manche[1]);
         chk("b_partita", int'(partita_b), e_partita[1]);
         chk("b_cnt",     int'(cnt_b),     m_cnt[1]);
      end
   end

   task automatic cyc(input logic ini, input logic [1:0] a, input logic [1:0] b);
      @(negedge clk);
      inizio  = ini;
      primo   = a;
      secondo = b;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int m, input int p, input int c);
      chk({name, "_manche"},  int'(manche_a),  m);
      chk({name, "_partita"}, int'(partita_a), p);
      chk({name, "_cnt"},     int'(cnt_a),     c);
   endtask

   initial begin
      // Draws to the base budget of 4
      cyc(1, 2'b00, 2'b00);
      lit("reset", 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 2'b01, 2'b01);
         lit("draw4", 3, (i == 4) ? 3 : 0, i);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 2'b10, 2'b01);
         lit("fine_hold", 0, 3, 4);
      end

      // Early end on lead, max 19, with the no-repeat veto in between
      cyc(1, 2'b11, 2'b11);
      cyc(0, 2'b10, 2'b01);
      lit("p1_r1", 2, 0, 1);
      cyc(0, 2'b10, 2'b11);
      lit("norepeat", 0, 0, 1);
      chk("b_repeat_allowed", int'(manche_b), 1);
      cyc(0, 2'b11, 2'b10);
      cyc(0, 2'b01, 2'b11);
      cyc(0, 2'b10, 2'b01);
      lit("early_end", 2, 2, 4);

      // Invalid move, then abort mid-match and replay with max 8
      cyc(1, 2'b00, 2'b00);
      cyc(0, 2'b00, 2'b10);
      lit("none_move", 0, 0, 0);
      cyc(0, 2'b01, 2'b11);
      lit("after_none", 2, 0, 1);
      cyc(0, 2'b11, 2'b11);
      cyc(0, 2'b10, 2'b10);
      lit("mid", 3, 0, 3);
      cyc(1, 2'b01, 2'b00);
      lit("abort", 0, 0, 0);
      for (int i = 1; i <= 8; i++) cyc(0, 2'b10, 2'b10);
      lit("draw8", 3, 3, 8);
      for (int i = 0; i < 3; i++) cyc(0, 2'b10, 2'b01);
      lit("fine_hold8", 0, 3, 8);

      // Player 2 takes the match, each win with a fresh move
      cyc(1, 2'b00, 2'b00);
      cyc(1, 2'b00, 2'b00);
      lit("hold_inizio", 0, 0, 0);
      cyc(0, 2'b01, 2'b10);
      cyc(0, 2'b11, 2'b01);
      cyc(0, 2'b10, 2'b11);
      cyc(0, 2'b01, 2'b10);
      lit("p2_match", 1, 1, 4);

      // Full budget of 19 draws
      cyc(1, 2'b11, 2'b11);
      for (int i = 1; i <= 18; i++) cyc(0, 2'b01, 2'b01);
      lit("draw18", 3, 0, 18);
      cyc(0, 2'b11, 2'b11);
      lit("draw19", 3, 3, 19);
      cyc(0, 2'b01, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
